mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between two requesters in the five-stage pipeline: instruction fetch (IF, read-only) and the MEM stage (load/store).
- Serialises accesses with a fixed-latency sequencer and only one transaction in flight at a time.
- Default priority goes to MEM, with an anti-starvation guard for IF.
- Produces per-port stall signals that the pipeline uses to freeze IF/ID or MEM/WB.

Parameters:
- ADDR_W, 8, memory word-address width.
- LAT, 1, memory access latency in cycles (legal values 1..7).
- MEM_RUN_MAX, 3, number of consecutive MEM grants allowed while IF waits before IF is forced.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  synchronous, active-high reset (port name kept per codebase convention).
- if_req  in  1  IF read request; held until if_ack.
- if_addr  in  ADDR_W  IF word address.
- if_ack  out  1  one-cycle completion pulse to IF.
- if_rdata  out  32  fetched word; valid while if_ack=1.
- if_stall  out  1  equals if_req & ~if_ack (combinational).
- dm_req  in  1  MEM-stage request; held until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  32  store data.
- dm_ack  out  1  one-cycle completion pulse to MEM stage.
- dm_rdata  out  32  load data; valid while dm_ack=1.
- dm_stall  out  1  equals dm_req & ~dm_ack (combinational).
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid in the LAT-th BUSY cycle.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (Resetn=1 at an edge):
  - state=IDLE, wait counter=0, run counter=0, owner=IF.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0.
  - Reset mid-transaction aborts it: no ack is issued and the memory is disabled the next cycle.
- IDLE:
  - No request: stay in IDLE; mem_en=0.
  - Arbitration is evaluated in every IDLE cycle:
    - Only dm_req: grant MEM.
    - Only if_req: grant IF.
    - Both requesting: grant IF if run counter == MEM_RUN_MAX, otherwise grant MEM.
  - On grant at the edge ending cycle t:
    - Latch owner and the address/we/wdata into the mem_* registers.
    - mem_en=1; mem_we=dm_we for a MEM grant, 0 for an IF grant.
    - Load wait counter=LAT−1 and go to BUSY.
- Run counter:
  - MEM grant while if_req=1: increment, saturating at MEM_RUN_MAX.
  - IF grant: clear.
  - MEM grant while if_req=0: clear.
- BUSY (cycles t+1..t+LAT):
  - mem_* outputs are held stable.
  - Wait counter decrements each cycle.
  - At the edge where the counter is 0: capture mem_rdata into the owner's rdata register (unchanged for writes), drop mem_en/mem_we, assert the owner's ack, go to DONE.
- DONE (cycle t+LAT+1):
  - Exactly one of if_ack/dm_ack is 1.
  - No arbitration happens in DONE; the next edge returns to IDLE.
  - Ack clears at that edge.
- rdata registers hold their last value between acks.
- Latency:
  - Grant to ack: LAT+1 cycles after the grant edge.
  - Minimum spacing between grants: LAT+2 cycles.
- Request inputs are sampled only in IDLE. Address/data changes during BUSY are ignored.
- A requester that drops req during BUSY still receives its ack pulse; the write still commits.
- A write acks with rdata unchanged.

Test Plan:
- Reset, then IF read only (LAT=1): if_req=1 with if_addr=0x04 in cycle 0; mem_rdata=0x8C010000 in cycle 1 → mem_en=1 and mem_addr=0x04 in cycle 1; if_ack=1 with if_rdata=0x8C010000 in cycle 2; if_stall=1 in cycles 0–1, 0 in cycle 2.
- MEM write (LAT=2): dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF → mem_we=1 for 2 cycles; dm_ack in cycle 3; dm_rdata unchanged.
- Simultaneous requests, both held continuously (MEM_RUN_MAX=3) → grant order MEM, MEM, MEM, IF, MEM…; run counter cleared after the IF grant.
- Back-to-back accesses: dm_req reasserted the cycle after dm_ack → next grant no earlier than the following IDLE; spacing between grants = LAT+2.
- Reset asserted in the BUSY cycle of an IF read → no if_ack; mem_en=0 the next cycle; state IDLE.
- Requester drops dm_req during BUSY of a write (LAT=3) → write still issued for 3 cycles; dm_ack still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-ported synchronous memory between
// instruction fetch and the MEM stage; one transaction in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int LAT         = 1,
  parameter int MEM_RUN_MAX = 3
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int RUN_W = (MEM_RUN_MAX < 2) ? 1 : $clog2(MEM_RUN_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MEM_RUN_MAX);
  localparam logic [2:0]       WAIT_INIT = 3'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [2:0]       wait_r;
  logic [RUN_W-1:0] run_r;
  logic             owner_dm_r;
  logic             grant_dm_s;
  logic             grant_if_s;
  logic             busy_done_s;

  // Next-state and arbitration; IF wins a tie only once MEM has run its quota
  always_comb begin
    state_s     = state_r;
    grant_dm_s  = 1'b0;
    grant_if_s  = 1'b0;
    busy_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (dm_req && (!if_req || (run_r != RUN_MAX))) begin
          grant_dm_s = 1'b1;
          state_s    = BUSY;
        end else if (if_req) begin
          grant_if_s = 1'b1;
          state_s    = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (wait_r == 3'd0) begin
          busy_done_s = 1'b1;
          state_s     = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: memory command registers, counters, acks and read data
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      wait_r     <= 3'd0;
      run_r      <= '0;
      owner_dm_r <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= 32'd0;
      dm_rdata   <= 32'd0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (grant_dm_s) begin
        owner_dm_r <= 1'b1;
        mem_en     <= 1'b1;
        mem_we     <= dm_we;
        mem_addr   <= dm_addr;
        mem_wdata  <= dm_wdata;
        wait_r     <= WAIT_INIT;
        if (!if_req) begin
          run_r <= '0;
        end else if (run_r != RUN_MAX) begin
          run_r <= run_r + RUN_W'(1);
        end else begin
          run_r <= run_r;
        end
      end else if (grant_if_s) begin
        owner_dm_r <= 1'b0;
        mem_en     <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        wait_r     <= WAIT_INIT;
        run_r      <= '0;
      end else if (busy_done_s) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        if (owner_dm_r) begin
          dm_ack <= 1'b1;
          if (!mem_we) begin
            dm_rdata <= mem_rdata;
          end
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end else if (state_r == BUSY) begin
        wait_r <= wait_r - 3'd1;
      end
    end
  end

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at LAT=1, 2 and 3
// share clock and reset, each driven through its own scenarios.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Per-instance signals: a_* LAT=1, b_* LAT=2, c_* LAT=3
  logic a_if_req, a_if_ack, a_if_stall, a_dm_req, a_dm_we, a_dm_ack, a_dm_stall, a_mem_en, a_mem_we;
  logic [7:0] a_if_addr, a_dm_addr, a_mem_addr;
  logic [31:0] a_if_rdata, a_dm_wdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
  logic b_if_req, b_if_ack, b_if_stall, b_dm_req, b_dm_we, b_dm_ack, b_dm_stall, b_mem_en, b_mem_we;
  logic [7:0] b_if_addr, b_dm_addr, b_mem_addr;
  logic [31:0] b_if_rdata, b_dm_wdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
  logic c_if_req, c_if_ack, c_if_stall, c_dm_req, c_dm_we, c_dm_ack, c_dm_stall, c_mem_en, c_mem_we;
  logic [7:0] c_if_addr, c_dm_addr, c_mem_addr;
  logic [31:0] c_if_rdata, c_dm_wdata, c_dm_rdata, c_mem_wdata, c_mem_rdata;

  mem_port_arbiter #(.ADDR_W(8), .LAT(1), .MEM_RUN_MAX(3)) u_a (
    .Clock(clk), .Resetn(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata), .if_stall(a_if_stall),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata), .dm_stall(a_dm_stall),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

  mem_port_arbiter #(.ADDR_W(8), .LAT(2), .MEM_RUN_MAX(3)) u_b (
    .Clock(clk), .Resetn(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata), .if_stall(b_if_stall),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata), .dm_stall(b_dm_stall),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

  mem_port_arbiter #(.ADDR_W(8), .LAT(3), .MEM_RUN_MAX(3)) u_c (
    .Clock(clk), .Resetn(rst),
    .if_req(c_if_req), .if_addr(c_if_addr), .if_ack(c_if_ack), .if_rdata(c_if_rdata), .if_stall(c_if_stall),
    .dm_req(c_dm_req), .dm_we(c_dm_we), .dm_addr(c_dm_addr), .dm_wdata(c_dm_wdata),
    .dm_ack(c_dm_ack), .dm_rdata(c_dm_rdata), .dm_stall(c_dm_stall),
    .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_if_req = 1'b0; a_if_addr = 8'h00; a_dm_req = 1'b0; a_dm_we = 1'b0; a_dm_addr = 8'h00;
    a_dm_wdata = 32'h0; a_mem_rdata = 32'h0;
    b_if_req = 1'b0; b_if_addr = 8'h00; b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = 8'h00;
    b_dm_wdata = 32'h0; b_mem_rdata = 32'h0;
    c_if_req = 1'b0; c_if_addr = 8'h00; c_dm_req = 1'b0; c_dm_we = 1'b0; c_dm_addr = 8'h00;
    c_dm_wdata = 32'h0; c_mem_rdata = 32'h0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_mem_en", {31'd0, a_mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, a_mem_we}, 32'd0);
    chk("rst_mem_addr", {24'd0, a_mem_addr}, 32'd0);
    chk("rst_mem_wdata", a_mem_wdata, 32'd0);
    chk("rst_if_ack", {31'd0, a_if_ack}, 32'd0);
    chk("rst_dm_ack", {31'd0, a_dm_ack}, 32'd0);
    chk("rst_if_rdata", a_if_rdata, 32'd0);
    chk("rst_dm_rdata", b_dm_rdata, 32'd0);

    // IF read, LAT=1
    a_if_req = 1'b1; a_if_addr = 8'h04; #1;
    chk("if_rd_c0_stall", {31'd0, a_if_stall}, 32'd1);
    chk("if_rd_c0_en", {31'd0, a_mem_en}, 32'd0);
    tick();
    a_mem_rdata = 32'h8C010000; #1;
    chk("if_rd_c1_en", {31'd0, a_mem_en}, 32'd1);
    chk("if_rd_c1_addr", {24'd0, a_mem_addr}, 32'h04);
    chk("if_rd_c1_we", {31'd0, a_mem_we}, 32'd0);
    chk("if_rd_c1_stall", {31'd0, a_if_stall}, 32'd1);
    chk("if_rd_c1_ack", {31'd0, a_if_ack}, 32'd0);
    tick();
    chk("if_rd_c2_ack", {31'd0, a_if_ack}, 32'd1);
    chk("if_rd_c2_rdata", a_if_rdata, 32'h8C010000);
    chk("if_rd_c2_stall", {31'd0, a_if_stall}, 32'd0);
    chk("if_rd_c2_en", {31'd0, a_mem_en}, 32'd0);
    chk("if_rd_c2_dm_ack", {31'd0, a_dm_ack}, 32'd0);
    a_if_req = 1'b0; a_mem_rdata = 32'h0;
    tick();
    chk("if_rd_c3_ack", {31'd0, a_if_ack}, 32'd0);
    chk("if_rd_c3_hold", a_if_rdata, 32'h8C010000);

    // MEM write, LAT=2, then back-to-back read
    b_dm_req = 1'b1; b_dm_we = 1'b1; b_dm_addr = 8'h10; b_dm_wdata = 32'hDEADBEEF;
    b_mem_rdata = 32'h12345678; #1;
    chk("wr_c0_stall", {31'd0, b_dm_stall}, 32'd1);
    tick();
    chk("wr_c1_en", {31'd0, b_mem_en}, 32'd1);
    chk("wr_c1_we", {31'd0, b_mem_we}, 32'd1);
    chk("wr_c1_addr", {24'd0, b_mem_addr}, 32'h10);
    chk("wr_c1_wdata", b_mem_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_c2_we", {31'd0, b_mem_we}, 32'd1);
    chk("wr_c2_ack", {31'd0, b_dm_ack}, 32'd0);
    tick();
    chk("wr_c3_ack", {31'd0, b_dm_ack}, 32'd1);
    chk("wr_c3_rdata", b_dm_rdata, 32'd0);
    chk("wr_c3_we", {31'd0, b_mem_we}, 32'd0);
    chk("wr_c3_en", {31'd0, b_mem_en}, 32'd0);
    b_dm_we = 1'b0; b_dm_addr = 8'h20; b_mem_rdata = 32'hCAFEF00D;
    tick();
    chk("b2b_c4_en", {31'd0, b_mem_en}, 32'd0);
    chk("b2b_c4_ack", {31'd0, b_dm_ack}, 32'd0);
    tick();
    chk("b2b_c5_en", {31'd0, b_mem_en}, 32'd1);
    chk("b2b_c5_addr", {24'd0, b_mem_addr}, 32'h20);
    chk("b2b_c5_we", {31'd0, b_mem_we}, 32'd0);
    tick();
    chk("b2b_c6_en", {31'd0, b_mem_en}, 32'd1);
    chk("b2b_c6_ack", {31'd0, b_dm_ack}, 32'd0);
    tick();
    chk("b2b_c7_ack", {31'd0, b_dm_ack}, 32'd1);
    chk("b2b_c7_rdata", b_dm_rdata, 32'hCAFEF00D);
    b_dm_req = 1'b0;
    tick();

    // Both requesting continuously on LAT=1: MEM MEM MEM IF MEM MEM
    a_if_req = 1'b1; a_if_addr = 8'h40; a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 8'h80;
    a_mem_rdata = 32'h5A5A0001;
    for (int k = 0; k < 6; k++) begin
      logic is_if;
      is_if = (k == 3);
      tick();
      chk($sformatf("prio_g%0d_en", k), {31'd0, a_mem_en}, 32'd1);
      chk($sformatf("prio_g%0d_addr", k), {24'd0, a_mem_addr}, is_if ? 32'h40 : 32'h80);
      tick();
      chk($sformatf("prio_g%0d_if_ack", k), {31'd0, a_if_ack}, {31'd0, is_if});
      chk($sformatf("prio_g%0d_dm_ack", k), {31'd0, a_dm_ack}, {31'd0, ~is_if});
      tick();
    end
    a_if_req = 1'b0; a_dm_req = 1'b0;
    tick(); tick(); tick();

    // Reset during BUSY of an IF read
    a_if_req = 1'b1; a_if_addr = 8'h08;
    tick();
    chk("rbusy_c1_en", {31'd0, a_mem_en}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rbusy_c2_en", {31'd0, a_mem_en}, 32'd0);
    chk("rbusy_c2_ack", {31'd0, a_if_ack}, 32'd0);
    chk("rbusy_c2_addr", {24'd0, a_mem_addr}, 32'd0);
    rst = 1'b0; a_if_req = 1'b0; a_dm_req = 1'b1; a_dm_addr = 8'h33;
    tick();
    chk("rbusy_c3_ack", {31'd0, a_if_ack}, 32'd0);
    chk("rbusy_c3_en", {31'd0, a_mem_en}, 32'd1);
    chk("rbusy_c3_addr", {24'd0, a_mem_addr}, 32'h33);
    tick();
    chk("rbusy_c4_dm_ack", {31'd0, a_dm_ack}, 32'd1);
    a_dm_req = 1'b0;
    tick();

    // Drop dm_req during BUSY of a write, LAT=3
    c_dm_req = 1'b1; c_dm_we = 1'b1; c_dm_addr = 8'h55; c_dm_wdata = 32'hA5A5A5A5;
    tick();
    chk("drop_c1_we", {31'd0, c_mem_we}, 32'd1);
    c_dm_req = 1'b0; c_dm_addr = 8'h66; c_dm_wdata = 32'h0; #1;
    chk("drop_c1_stall", {31'd0, c_dm_stall}, 32'd0);
    tick();
    chk("drop_c2_we", {31'd0, c_mem_we}, 32'd1);
    chk("drop_c2_addr", {24'd0, c_mem_addr}, 32'h55);
    chk("drop_c2_wdata", c_mem_wdata, 32'hA5A5A5A5);
    tick();
    chk("drop_c3_we", {31'd0, c_mem_we}, 32'd1);
    chk("drop_c3_ack", {31'd0, c_dm_ack}, 32'd0);
    tick();
    chk("drop_c4_ack", {31'd0, c_dm_ack}, 32'd1);
    chk("drop_c4_we", {31'd0, c_mem_we}, 32'd0);
    tick();
    chk("drop_c5_ack", {31'd0, c_dm_ack}, 32'd0);
    tick();
    chk("drop_c6_ack", {31'd0, c_dm_ack}, 32'd0);
    chk("drop_c6_en", {31'd0, c_mem_en}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
